// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops bytes from the TX FIFO and frames them onto the serial line.
// Optional parity bit (parity_odd port, PARITY state) is built when UART_TX_PARITY_EN is defined.
module uart_tx_engine #(
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned BAUD_DIV  = 868,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              a_resetn,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_r_data,
`ifdef UART_TX_PARITY_EN
    input  logic              parity_odd,
`endif
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam int unsigned IW = $clog2(DWIDTH) + 1;

    localparam logic [CW-1:0] BaudMax  = CW'(BAUD_DIV - 1);
    localparam logic [IW-1:0] LastBit  = IW'(DWIDTH - 1);
    localparam logic [IW-1:0] LastStop = IW'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle, StFetch, StLoad, StStart, StData, StParity, StStop
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StFetch, StLoad, StStart, StData, StStop
    } state_e;
`endif

    state_e            state_q;
    logic [CW-1:0]     baud_cnt_q;
    logic [IW-1:0]     bit_idx_q;
    logic [DWIDTH-1:0] shift_q;
`ifdef UART_TX_PARITY_EN
    logic              parity_q;
`endif

    logic bit_end;
    logic start_ok;
    logic timing;

    assign bit_end  = (baud_cnt_q == BaudMax);
    assign start_ok = tx_en & ~fifo_empty;
    assign fifo_rd  = (state_q == StFetch);
    assign timing   = (state_q == StStart) || (state_q == StData) ||
`ifdef UART_TX_PARITY_EN
                      (state_q == StParity) ||
`endif
                      (state_q == StStop);

    // tx is assigned alongside each state transition so it always reflects the state it enters.
    always_ff @(posedge clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
            tx         <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (timing) begin
                baud_cnt_q <= bit_end ? '0 : baud_cnt_q + CW'(1);
            end
            case (state_q)
                StIdle: begin
                    tx <= 1'b1;
                    if (start_ok) begin
                        state_q <= StFetch;
                        busy    <= 1'b1;
                    end
                end
                StFetch: state_q <= StLoad;
                StLoad: begin
                    shift_q    <= fifo_r_data;
                    baud_cnt_q <= '0;
                    bit_idx_q  <= '0;
`ifdef UART_TX_PARITY_EN
                    parity_q   <= 1'b0;
`endif
                    tx         <= 1'b0;
                    state_q    <= StStart;
                end
                StStart: begin
                    if (bit_end) begin
                        tx      <= shift_q[0];
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
`ifdef UART_TX_PARITY_EN
                        parity_q <= parity_q ^ shift_q[0];
`endif
                        if (bit_idx_q == LastBit) begin
                            bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                            tx      <= parity_q ^ shift_q[0] ^ parity_odd;
                            state_q <= StParity;
`else
                            tx      <= 1'b1;
                            state_q <= StStop;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + IW'(1);
                            tx        <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        tx      <= 1'b1;
                        state_q <= StStop;
                    end
                end
`endif
                StStop: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        if (bit_idx_q == LastStop) begin
                            bit_idx_q <= '0;
                            tx_done   <= 1'b1;
                            if (start_ok) begin
                                state_q <= StFetch;
                            end else begin
                                state_q <= StIdle;
                                busy    <= 1'b0;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + IW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine at BAUD_DIV=4 with a small queue-based FIFO model.
// The parity build (UART_TX_PARITY_EN) also runs with two stop bits.
module tb_uart_tx_engine;

    localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P     = 1;
    localparam int NSTOP = 2;
`else
    localparam int P     = 0;
    localparam int NSTOP = 1;
`endif
    localparam int NBITS = 1 + 8 + P + NSTOP;
    localparam int FRAME = NBITS * BD;

    logic       clk = 1'b0;
    logic       a_resetn;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_r_data;
    logic       parity_odd;
    logic       fifo_rd;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [16];
    int wr_ptr = 0;
    int rd_ptr = 0;

    logic cap_tx   [512];
    logic cap_rd   [512];
    logic cap_done [512];
    logic cap_busy [512];

    uart_tx_engine #(
        .DWIDTH   (8),
        .BAUD_DIV (BD),
        .STOP_BITS(NSTOP)
    ) dut (
        .clk        (clk),
        .a_resetn   (a_resetn),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_r_data(fifo_r_data),
`ifdef UART_TX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // FIFO read data appears the cycle after the pop strobe is sampled.
    always @(posedge clk) begin
        if (fifo_rd && (wr_ptr != rd_ptr)) begin
            fifo_r_data <= mem[rd_ptr % 16];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    function automatic logic exp_bit(input logic [7:0] d, input int k, input logic podd);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (P == 1 && k == 9) return (^d) ^ podd;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr % 16] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic capture(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            cap_tx[base+i]   = tx;
            cap_rd[base+i]   = fifo_rd;
            cap_done[base+i] = tx_done;
            cap_busy[base+i] = busy;
        end
    endtask

    task automatic test_reset();
        a_resetn = 1'b0;
        repeat (3) tick();
        checks += 4;
        if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b want 1", tx); end
        if (fifo_rd !== 1'b0) begin failures++; $display("FAIL reset_rd: got %b want 0", fifo_rd); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (tx_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", tx_done); end
        a_resetn = 1'b1;
        capture(0, 5);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cap_tx[i] !== 1'b1 || cap_rd[i] !== 1'b0 || cap_busy[i] !== 1'b0) begin
                failures++;
                $display("FAIL idle_after_reset[%0d]: got tx=%b rd=%b busy=%b want 1 0 0",
                         i, cap_tx[i], cap_rd[i], cap_busy[i]);
            end
        end
    endtask

    task automatic test_single_frame();
        int rd_cnt;
        int done_cnt;
        push(8'hA5);
        tx_en = 1'b1;
        capture(0, 2 + FRAME + 10);
        rd_cnt   = 0;
        done_cnt = 0;
        for (int i = 0; i < 2 + FRAME + 10; i++) begin
            rd_cnt   += int'(cap_rd[i]);
            done_cnt += int'(cap_done[i]);
        end
        checks += 6;
        if (rd_cnt != 1) begin failures++; $display("FAIL a5_rd_count: got %0d want 1", rd_cnt); end
        if (cap_rd[0] !== 1'b1) begin failures++; $display("FAIL a5_rd_first: got %b want 1", cap_rd[0]); end
        if (cap_busy[0] !== 1'b1) begin failures++; $display("FAIL a5_busy_fetch: got %b want 1", cap_busy[0]); end
        if (done_cnt != 1) begin failures++; $display("FAIL a5_done_count: got %0d want 1", done_cnt); end
        if (cap_done[2+FRAME] !== 1'b1) begin
            failures++; $display("FAIL a5_done_pos: got %b want 1", cap_done[2+FRAME]);
        end
        if (cap_busy[2+FRAME] !== 1'b0) begin
            failures++; $display("FAIL a5_busy_after: got %b want 0", cap_busy[2+FRAME]);
        end
        for (int k = 0; k < NBITS; k++) begin
            for (int c = 0; c < BD; c++) begin
                checks++;
                if (cap_tx[2+k*BD+c] !== exp_bit(8'hA5, k, 1'b0)) begin
                    failures++;
                    $display("FAIL a5_bit%0d_cyc%0d: got %b want %b", k, c, cap_tx[2+k*BD+c],
                             exp_bit(8'hA5, k, 1'b0));
                end
            end
        end
        tx_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int rd_first;
        int rd_second;
        int rd_cnt;
        int g;
        push(8'h00);
        push(8'hFF);
        tx_en = 1'b1;
        capture(0, 2 * (FRAME + 2) + 10);
        rd_cnt = 0; rd_first = -1; rd_second = -1;
        for (int i = 0; i < 2 * (FRAME + 2) + 10; i++) begin
            if (cap_rd[i] === 1'b1) begin
                if (rd_cnt == 0) rd_first = i;
                if (rd_cnt == 1) rd_second = i;
                rd_cnt++;
            end
        end
        g = 2 + FRAME;
        checks += 7;
        if (rd_cnt != 2) begin failures++; $display("FAIL b2b_rd_count: got %0d want 2", rd_cnt); end
        if (rd_second - rd_first != FRAME + 2) begin
            failures++; $display("FAIL b2b_rd_spacing: got %0d want %0d", rd_second - rd_first, FRAME + 2);
        end
        if (cap_tx[g-1] !== 1'b1 || cap_tx[g] !== 1'b1 || cap_tx[g+1] !== 1'b1) begin
            failures++; $display("FAIL b2b_gap_high: got %b%b%b want 111", cap_tx[g-1], cap_tx[g], cap_tx[g+1]);
        end
        if (cap_tx[g+2] !== 1'b0) begin failures++; $display("FAIL b2b_second_start: got %b want 0", cap_tx[g+2]); end
        if (cap_done[g] !== 1'b1) begin failures++; $display("FAIL b2b_done1: got %b want 1", cap_done[g]); end
        if (cap_busy[g] !== 1'b1 || cap_busy[g+1] !== 1'b1) begin
            failures++; $display("FAIL b2b_busy_gap: got %b%b want 11", cap_busy[g], cap_busy[g+1]);
        end
        if (cap_done[g+FRAME+2] !== 1'b1) begin
            failures++; $display("FAIL b2b_done2: got %b want 1", cap_done[g+FRAME+2]);
        end
        for (int k = 0; k < NBITS; k++) begin
            checks += 2;
            if (cap_tx[2+k*BD+1] !== exp_bit(8'h00, k, 1'b0)) begin
                failures++; $display("FAIL b2b_00_bit%0d: got %b want %b", k, cap_tx[2+k*BD+1], exp_bit(8'h00, k, 1'b0));
            end
            if (cap_tx[g+2+k*BD+1] !== exp_bit(8'hFF, k, 1'b0)) begin
                failures++; $display("FAIL b2b_ff_bit%0d: got %b want %b", k, cap_tx[g+2+k*BD+1], exp_bit(8'hFF, k, 1'b0));
            end
        end
        tx_en = 1'b0;
    endtask

    task automatic test_tx_en_gate();
        int bad;
        push(8'h5A);
        tx_en = 1'b0;
        capture(0, 100);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (cap_rd[i] !== 1'b0 || cap_tx[i] !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL gate_idle: got %0d bad cycles want 0", bad); end
        tx_en = 1'b1;
        capture(0, FRAME + 6);
        checks += 3;
        if (cap_rd[0] !== 1'b1) begin failures++; $display("FAIL gate_rd: got %b want 1", cap_rd[0]); end
        if (cap_tx[1] !== 1'b1) begin failures++; $display("FAIL gate_pre_start: got %b want 1", cap_tx[1]); end
        if (cap_tx[2] !== 1'b0) begin failures++; $display("FAIL gate_start_latency: got %b want 0", cap_tx[2]); end
        for (int k = 1; k < NBITS; k++) begin
            checks++;
            if (cap_tx[2+k*BD+2] !== exp_bit(8'h5A, k, 1'b0)) begin
                failures++; $display("FAIL gate_5a_bit%0d: got %b want %b", k, cap_tx[2+k*BD+2], exp_bit(8'h5A, k, 1'b0));
            end
        end
        tx_en = 1'b0;
    endtask

    task automatic test_drop_en();
        int rd_cnt;
        push(8'h3C);
        push(8'h81);
        tx_en = 1'b1;
        capture(0, 2 + 4 * BD + 1);
        tx_en = 1'b0;
        capture(2 + 4 * BD + 1, FRAME - 4 * BD + 40);
        rd_cnt = 0;
        for (int i = 0; i < FRAME + 42; i++) rd_cnt += int'(cap_rd[i]);
        checks += 3;
        if (rd_cnt != 1) begin failures++; $display("FAIL drop_rd_count: got %0d want 1", rd_cnt); end
        if (cap_done[2+FRAME] !== 1'b1) begin failures++; $display("FAIL drop_done: got %b want 1", cap_done[2+FRAME]); end
        if (cap_busy[2+FRAME] !== 1'b0) begin failures++; $display("FAIL drop_busy: got %b want 0", cap_busy[2+FRAME]); end
        for (int k = 0; k < NBITS; k++) begin
            for (int c = 0; c < BD; c++) begin
                checks++;
                if (cap_tx[2+k*BD+c] !== exp_bit(8'h3C, k, 1'b0)) begin
                    failures++; $display("FAIL drop_3c_bit%0d_cyc%0d: got %b want %b", k, c,
                                         cap_tx[2+k*BD+c], exp_bit(8'h3C, k, 1'b0));
                end
            end
        end
    endtask

    // 0x81 is left queued by test_drop_en; its data bit 5 is 0, so the line is low at reset.
    task automatic test_async_reset();
        int bad;
        tx_en = 1'b1;
        capture(0, 2 + 6 * BD + 1);
        checks += 2;
        if (cap_rd[0] !== 1'b1) begin failures++; $display("FAIL arst_rd: got %b want 1", cap_rd[0]); end
        if (cap_tx[2+6*BD] !== 1'b0) begin failures++; $display("FAIL arst_bit5: got %b want 0", cap_tx[2+6*BD]); end
        a_resetn = 1'b0;
        #1;
        checks += 3;
        if (tx !== 1'b1) begin failures++; $display("FAIL arst_tx: got %b want 1", tx); end
        if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy: got %b want 0", busy); end
        if (fifo_rd !== 1'b0) begin failures++; $display("FAIL arst_fifo_rd: got %b want 0", fifo_rd); end
        #2;
        a_resetn = 1'b1;
        capture(0, 60);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            if (cap_rd[i] !== 1'b0 || cap_tx[i] !== 1'b1 || cap_busy[i] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL arst_idle_after: got %0d bad cycles want 0", bad); end
        tx_en = 1'b0;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        for (int p = 0; p < 2; p++) begin
            parity_odd = p[0];
            push(8'h07);
            tx_en = 1'b1;
            capture(0, 2 + FRAME + 4);
            tx_en = 1'b0;
            for (int c = 0; c < BD; c++) begin
                checks++;
                if (cap_tx[2+9*BD+c] !== ~p[0]) begin
                    failures++; $display("FAIL parity_odd%0d_cyc%0d: got %b want %b", p, c, cap_tx[2+9*BD+c], ~p[0]);
                end
            end
            for (int c = 1; c <= 2 * BD; c++) begin
                checks++;
                if (cap_tx[2+FRAME-c] !== 1'b1) begin
                    failures++; $display("FAIL parity_stop%0d_back%0d: got %b want 1", p, c, cap_tx[2+FRAME-c]);
                end
            end
            checks += 2;
            if (cap_done[2+FRAME] !== 1'b1 || cap_done[2+FRAME-1] !== 1'b0) begin
                failures++; $display("FAIL parity_done%0d: got %b%b want 01", p, cap_done[2+FRAME-1], cap_done[2+FRAME]);
            end
            if (cap_tx[2+FRAME-2*BD-1] !== ~p[0]) begin
                failures++; $display("FAIL parity_before_stop%0d: got %b want %b", p, cap_tx[2+FRAME-2*BD-1], ~p[0]);
            end
        end
        parity_odd = 1'b0;
    endtask
`endif

    initial begin
        a_resetn   = 1'b0;
        tx_en      = 1'b0;
        parity_odd = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_tx_en_gate();
        test_drop_en();
        test_async_reset();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
